rc_pwm_capture: RTL and testbench
=================================

# rc_pwm_capture

Measures the high time of an incoming RC/servo-style PWM pulse train, validates and filters it, and converts the pulse width into a 16-bit speed command. It sits in front of the motor PWM generator: it drives `speed_out`/`speed_oe` into the generator's `speed_in`/`speed_oe`, and honours the generator's `busy` output. It also provides a signal-loss failsafe that commands speed 0.

## Interface
- `MIN_W`, 50000: pulse width in clk cycles that maps to speed 0 (1.0 ms at 50 MHz).
- `SPAN_LOG2`, 16: log2 of the width span in cycles that maps to the full scale. `MAX_W = MIN_W + 2**SPAN_LOG2`. Legal range 8..16.
- `CNT_W`, 18: width counter bits. `MAX_W` must be less than `2**CNT_W - 1`.
- `FILT`, 4: number of consecutive equal synchronized samples needed to change the filtered line. Must be ≥1.
- `TIMEOUT_CYC`, 1500000: cycles without an accepted pulse before signal loss is declared (30 ms).
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `pwm_in`  in  1  raw asynchronous PWM input, active-high pulse.
- `busy`  in  1  downstream busy. No command is issued while it is high.
- `speed_out`  out  16  last issued speed command.
- `speed_oe`  out  1  one-cycle strobe; `speed_out` is valid in the same cycle.
- `lost`  out  1  signal-loss flag.
- `pulse_err`  out  1  one-cycle strobe when a pulse is rejected.

## Operation
- **Input conditioning**
  - `pwm_in` passes through a 2-flop synchronizer, then a glitch filter.
  - The filtered line `f` toggles only after FILT consecutive synchronized samples differ from the current `f`.
  - Both edges are delayed equally, so the measured width equals the raw width for clean input.
- **State machine** (ARM, IDLE, MEAS)
  - ARM, the reset state: wait for `f`=0, then go to IDLE. This prevents measuring a partial pulse after reset or an error.
  - IDLE: on a rising edge of `f`, clear `wcnt` to 1 and go to MEAS.
  - MEAS: increment `wcnt` each cycle `f`=1.
  - MEAS, falling edge of `f`: evaluate width `w=wcnt` and go to IDLE.
  - MEAS, `wcnt` reaches `2**CNT_W-1` (stuck high): pulse `pulse_err`, discard the pulse, go to ARM.
- **Width evaluation**
  - `w < MIN_W/2`: rejected. Pulse `pulse_err`; no result is produced and the timeout counter is not cleared.
  - `MIN_W/2 ≤ w ≤ MIN_W`: result 0.
  - `MIN_W < w < MAX_W`: result `(w-MIN_W) << (16-SPAN_LOG2)`, truncated to 16 bits.
  - `w ≥ MAX_W`: result 65535.
  - Any non-rejected pulse is "accepted". Acceptance clears the timeout counter and `lost`.
- **Timeout**
  - `tcnt` increments every cycle and saturates at TIMEOUT_CYC.
  - On the cycle `tcnt` reaches TIMEOUT_CYC: set `lost`=1 and load the result 0 into pending (failsafe).
  - The failsafe fires once per loss episode.
- **Handshake**
  - Each result writes pending value `pv` and sets the pending flag `pf`. A newer result overwrites an unissued one (latest wins).
  - Issue condition, at a clock edge: `pf`=1, `busy`=0, and `speed_oe` currently 0. On issue: `speed_oe`←1, `speed_out`←`pv`, `pf`←0.
  - If a new result arrives on the issue edge, the old value is issued and `pf` stays 1 with the new value.
  - `speed_oe` is never high on two consecutive cycles. This covers the cycle before the downstream raises `busy`.

## Timing
- **Reset values:** `speed_out`=0, `speed_oe`=0, `lost`=1, `pulse_err`=0. State ARM, `pf`=0, `tcnt`=0.
- **Reset mid-operation:** any partial pulse and pending value are dropped, and the block must see `f` low before measuring.
- **Input latency:** 2 sync cycles plus FILT filter cycles from a raw edge to the corresponding `f` edge.
- **Result latency:** the result registers into `pv` 1 cycle after the `f` falling edge.
- **End-to-end latency:** with `busy`=0, `speed_oe` asserts FILT+4 cycles after the first clk edge that samples `pwm_in` low.
- **`busy` high:** the issue is held; `speed_oe` asserts on the first edge with `busy`=0.
- **Error strobe:** `pulse_err` asserts 1 cycle after the rejecting `f` edge or after `wcnt` saturation.
- **Failsafe latency:** the failsafe `speed_oe` follows the `tcnt` saturation by 1 cycle, subject to `busy`.
- **Simultaneous events:** if an accepted pulse is evaluated on the same edge that `tcnt` saturates, the pulse wins. `lost` stays 0 and `pv` takes the pulse result.

## Test plan
- **Nominal widths:** after reset, 20 ms-period pulses of width 50000, 82768, 115536 and 120000 cycles with `busy`=0 → `speed_oe` with `speed_out` = 0, 32768, 65535, 65535. Each strobe is FILT+4 cycles after the fall, and `lost` drops at the first pulse.
- **Rejects and glitches:** a 20000-cycle pulse → `pulse_err` strobe, no `speed_oe`. A 3-cycle high glitch inside a low period, and a 3-cycle low glitch inside an 82768-cycle pulse → ignored, width still decodes to 32768.
- **Busy hold and overwrite:** hold `busy`=1 across two pulses (70000, then 90000) → no strobe while busy. A single `speed_oe` with 40000 follows 1 cycle after `busy` falls.
- **Back-to-back guard:** a new result lands on the issue edge with `busy`=0 → two strobes separated by at least one low cycle, in order.
- **Timeout failsafe:** valid pulses, then `pwm_in` held low for 1.6M cycles → `lost`=1 and one `speed_oe` with 0, 1.5M cycles after the last accepted pulse. A following 82768 pulse → `lost`=0, `speed_out`=32768.
- **Stuck high and reset:**
  - Hold `pwm_in` high for 300000 cycles → `pulse_err`, no `speed_oe`, and a following pulse is measured only after a low level.
  - Assert `rst_n` mid-pulse, then release while `pwm_in` is still high → the partial pulse is ignored and outputs are at reset values.

Source files
------------

// File: rtl/rc_pwm_capture.sv
// RC/servo pulse-width capture: synchronizes and deglitches pwm_in, measures the high time,
// maps it to a 16-bit speed command and hands it to the motor PWM generator with a loss failsafe.
module rc_pwm_capture #(
    parameter int MIN_W       = 50000,
    parameter int SPAN_LOG2   = 16,
    parameter int CNT_W       = 18,
    parameter int FILT        = 4,
    parameter int TIMEOUT_CYC = 1500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    input  logic        busy,
    output logic [15:0] speed_out,
    output logic        speed_oe,
    output logic        lost,
    output logic        pulse_err
);
    localparam int MAX_W  = MIN_W + (2 ** SPAN_LOG2);
    localparam int FCNT_W = $clog2(FILT + 1);
    localparam int TCNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0]  HALF_W_C = CNT_W'(MIN_W / 2);
    localparam logic [CNT_W-1:0]  MIN_W_C  = CNT_W'(MIN_W);
    localparam logic [CNT_W-1:0]  MAX_W_C  = CNT_W'(MAX_W);
    localparam logic [CNT_W-1:0]  WSAT_C   = {CNT_W{1'b1}};
    localparam logic [FCNT_W-1:0] FILT_C   = FCNT_W'(FILT);
    localparam logic [TCNT_W-1:0] TMO_C    = TCNT_W'(TIMEOUT_CYC);
    localparam logic [TCNT_W-1:0] TMO_M1_C = TCNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {ARM = 2'd0, IDLE = 2'd1, MEAS = 2'd2} state_t;

    logic              sync1_r, sync2_r, f_r;
    logic [FCNT_W-1:0] fcnt_r;
    state_t            state_r;
    logic [CNT_W-1:0]  wcnt_r;
    logic [TCNT_W-1:0] tcnt_r;
    logic              lost_r, pulse_err_r, pf_r, speed_oe_r;
    logic [15:0]       pv_r, speed_out_r;

    logic              rej_s, eval_s, accept_s, sat_s, fs_s, new_s, issue_s;
    logic [15:0]       res_s, new_val_s;
    logic [CNT_W-1:0]  diff_s;

    // Synchronizer and glitch filter; sync and f reset high so a pulse already in
    // progress at reset release is never measured.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
            f_r     <= 1'b1;
            fcnt_r  <= '0;
        end else begin
            sync1_r <= pwm_in;
            sync2_r <= sync1_r;
            if (sync2_r != f_r) begin
                if (fcnt_r == FILT_C) begin
                    f_r    <= sync2_r;
                    fcnt_r <= '0;
                end else begin
                    fcnt_r <= fcnt_r + FCNT_W'(1);
                end
            end else begin
                fcnt_r <= '0;
            end
        end
    end

    // Width classification and speed mapping of the measured pulse.
    always_comb begin
        res_s  = 16'd0;
        rej_s  = 1'b0;
        diff_s = wcnt_r - MIN_W_C;
        if (wcnt_r < HALF_W_C) begin
            rej_s = 1'b1;
        end else if (wcnt_r <= MIN_W_C) begin
            res_s = 16'd0;
        end else if (wcnt_r < MAX_W_C) begin
            res_s = 16'(32'(diff_s) << (16 - SPAN_LOG2));
        end else begin
            res_s = 16'hFFFF;
        end
    end

    assign eval_s    = (state_r == MEAS) && !f_r;
    assign accept_s  = eval_s && !rej_s;
    assign sat_s     = (state_r == MEAS) && f_r && (wcnt_r == WSAT_C);
    assign fs_s      = (tcnt_r == TMO_M1_C) && !accept_s;
    assign new_s     = accept_s || fs_s;
    assign new_val_s = accept_s ? res_s : 16'd0;
    assign issue_s   = pf_r && !busy && !speed_oe_r;

    // Pulse measurement state machine with error strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ARM;
            wcnt_r      <= '0;
            pulse_err_r <= 1'b0;
        end else begin
            pulse_err_r <= (eval_s && rej_s) || sat_s;
            case (state_r)
                ARM: begin
                    if (!f_r) state_r <= IDLE;
                    else      state_r <= ARM;
                end
                IDLE: begin
                    if (f_r) begin
                        wcnt_r  <= CNT_W'(1);
                        state_r <= MEAS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MEAS: begin
                    if (!f_r)                  state_r <= IDLE;
                    else if (wcnt_r == WSAT_C) state_r <= ARM;
                    else                       wcnt_r  <= wcnt_r + CNT_W'(1);
                end
                default: state_r <= ARM;
            endcase
        end
    end

    // Signal-loss timer; an accepted pulse on the saturating edge takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_r <= '0;
            lost_r <= 1'b1;
        end else if (accept_s) begin
            tcnt_r <= '0;
            lost_r <= 1'b0;
        end else if (fs_s) begin
            tcnt_r <= TMO_C;
            lost_r <= 1'b1;
        end else if (tcnt_r != TMO_C) begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
        end else begin
            tcnt_r <= tcnt_r;
        end
    end

    // Latest-wins pending slot and spaced-out issue strobe towards the generator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pf_r        <= 1'b0;
            pv_r        <= 16'd0;
            speed_oe_r  <= 1'b0;
            speed_out_r <= 16'd0;
        end else begin
            speed_oe_r <= issue_s;
            if (issue_s) speed_out_r <= pv_r;
            else         speed_out_r <= speed_out_r;
            if (new_s) begin
                pf_r <= 1'b1;
                pv_r <= new_val_s;
            end else if (issue_s) begin
                pf_r <= 1'b0;
            end else begin
                pf_r <= pf_r;
            end
        end
    end

    assign speed_out = speed_out_r;
    assign speed_oe  = speed_oe_r;
    assign lost      = lost_r;
    assign pulse_err = pulse_err_r;
endmodule

// File: tb/tb_rc_pwm_capture.sv
// Directed bench for rc_pwm_capture with shrunk timing parameters (MIN_W=100, span 256,
// FILT=4, timeout 3000); expected speeds and strobe cycles are hand-computed.
module tb_rc_pwm_capture;
    localparam int FILT = 4;
    localparam int TMO  = 3000;
    localparam int LAT  = FILT + 4;

    logic        clk = 1'b0;
    logic        rst_n, pwm_in, busy;
    logic [15:0] speed_out;
    logic        speed_oe, lost, pulse_err;

    int total = 0, bad = 0;
    int cyc = 0;
    int oe_cnt = 0, err_cnt = 0, last_val = 0, prev_val = 0, last_cyc = 0, prev_cyc = 0;
    logic b2b = 1'b0, oe_prev = 1'b0;
    int e0, n0, k0, exp_cyc;

    rc_pwm_capture #(
        .MIN_W(100), .SPAN_LOG2(8), .CNT_W(10), .FILT(FILT), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in), .busy(busy),
        .speed_out(speed_out), .speed_oe(speed_oe), .lost(lost), .pulse_err(pulse_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        oe_prev <= speed_oe;
        if (speed_oe) begin
            oe_cnt   <= oe_cnt + 1;
            prev_val <= last_val;
            last_val <= int'(speed_out);
            prev_cyc <= last_cyc;
            last_cyc <= cyc;
            if (oe_prev) b2b <= 1'b1;
        end
        if (pulse_err) err_cnt <= err_cnt + 1;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic do_pulse(input int w);
        pwm_in = 1'b1;
        step(w);
        pwm_in = 1'b0;
        e0 = cyc + 1;
    endtask

    task automatic run_w(input string tag, input int w, input int expv);
        n0 = oe_cnt;
        do_pulse(w);
        step(20);
        chk({tag, "_cnt"}, oe_cnt, n0 + 1);
        chk({tag, "_val"}, last_val, expv);
        chk({tag, "_lat"}, last_cyc, e0 + LAT);
        chk({tag, "_lost"}, int'(lost), 0);
    endtask

    task automatic rej_w(input string tag, input int w);
        n0 = oe_cnt;
        k0 = err_cnt;
        do_pulse(w);
        step(20);
        chk({tag, "_no_oe"}, oe_cnt, n0);
        chk({tag, "_err"}, err_cnt, k0 + 1);
    endtask

    initial begin
        rst_n = 1'b0; pwm_in = 1'b0; busy = 1'b0;
        step(3);
        chk("rst_speed_out", int'(speed_out), 0);
        chk("rst_speed_oe", int'(speed_oe), 0);
        chk("rst_lost", int'(lost), 1);
        chk("rst_pulse_err", int'(pulse_err), 0);
        rst_n = 1'b1;
        step(20);

        // Nominal and boundary widths
        run_w("w100", 100, 0);
        run_w("w228", 228, 32768);
        run_w("w356", 356, 65535);
        run_w("w400", 400, 65535);
        run_w("w355", 355, 65280);
        run_w("w101", 101, 256);
        run_w("w50", 50, 0);
        rej_w("w49", 49);
        rej_w("w20", 20);

        // Short high glitch in the low period
        n0 = oe_cnt; k0 = err_cnt;
        pwm_in = 1'b1; step(3); pwm_in = 1'b0; step(20);
        chk("hglitch_no_oe", oe_cnt, n0);
        chk("hglitch_no_err", err_cnt, k0);

        // Short low glitch inside a 228-cycle pulse
        n0 = oe_cnt;
        pwm_in = 1'b1; step(100); pwm_in = 1'b0; step(3); pwm_in = 1'b1; step(125);
        pwm_in = 1'b0; e0 = cyc + 1; step(20);
        chk("lglitch_cnt", oe_cnt, n0 + 1);
        chk("lglitch_val", last_val, 32768);
        chk("lglitch_lat", last_cyc, e0 + LAT);

        // Busy hold with overwrite
        n0 = oe_cnt;
        busy = 1'b1;
        do_pulse(200); step(20);
        do_pulse(250); step(20);
        chk("busy_hold", oe_cnt, n0);
        busy = 1'b0; exp_cyc = cyc + 1;
        step(5);
        chk("busy_cnt", oe_cnt, n0 + 1);
        chk("busy_val", last_val, 38400);
        chk("busy_lat", last_cyc, exp_cyc);

        // New result lands on the issue edge
        n0 = oe_cnt;
        busy = 1'b1;
        do_pulse(150); step(20);
        do_pulse(300);
        step(FILT + 3);
        busy = 1'b0;
        step(10);
        chk("b2b_cnt", oe_cnt, n0 + 2);
        chk("b2b_first_val", prev_val, 12800);
        chk("b2b_second_val", last_val, 51200);
        chk("b2b_first_cyc", prev_cyc, e0 + FILT + 3);
        chk("b2b_second_cyc", last_cyc, e0 + FILT + 5);
        chk("b2b_gap", int'(b2b), 0);
        chk("pre_tmo_lost", int'(lost), 0);

        // Timeout failsafe, once per episode
        n0 = oe_cnt;
        step(3200);
        chk("tmo_lost", int'(lost), 1);
        chk("tmo_cnt", oe_cnt, n0 + 1);
        chk("tmo_val", last_val, 0);
        chk("tmo_lat", last_cyc, e0 + FILT + 4 + TMO);
        step(300);
        chk("tmo_once", oe_cnt, n0 + 1);
        run_w("recover", 228, 32768);

        // Stuck-high input saturates the width counter
        n0 = oe_cnt; k0 = err_cnt;
        pwm_in = 1'b1; step(1200); pwm_in = 1'b0; step(20);
        chk("stuck_err", err_cnt, k0 + 1);
        chk("stuck_no_oe", oe_cnt, n0);
        run_w("post_stuck", 228, 32768);

        // Reset in the middle of a pulse, released while still high
        pwm_in = 1'b1; step(50);
        rst_n = 1'b0; step(2);
        chk("mrst_speed_out", int'(speed_out), 0);
        chk("mrst_lost", int'(lost), 1);
        chk("mrst_speed_oe", int'(speed_oe), 0);
        rst_n = 1'b1;
        n0 = oe_cnt; k0 = err_cnt;
        step(100); pwm_in = 1'b0; step(20);
        chk("mrst_no_oe", oe_cnt, n0);
        chk("mrst_no_err", err_cnt, k0);
        run_w("post_rst", 356, 65535);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
